// File: rtl/a5_keystream_gen_pkg.sv
// a5_pkg: shared FSM state type, default A5/1 geometry and bit helpers
// Contents:
//   state_t    - session FSM states
//   A5_*       - default register lengths, feedback masks and clocking taps
//   majority() - 2-of-3 vote used for irregular clocking
//   parity()   - XOR reduction of a value under a feedback mask (up to 64 bits)
package a5_pkg;

    typedef enum logic [2:0] {IDLE, LOADK, LOADF, MIX, GEN} state_t;

    localparam int          A5_R1LEN = 19;
    localparam int          A5_R2LEN = 22;
    localparam int          A5_R3LEN = 23;
    localparam logic [18:0] A5_TAPS1 = 19'h72000;
    localparam logic [21:0] A5_TAPS2 = 22'h300000;
    localparam logic [22:0] A5_TAPS3 = 23'h700080;
    localparam int          A5_CLK1  = 8;
    localparam int          A5_CLK2  = 10;
    localparam int          A5_CLK3  = 10;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity(input logic [63:0] v, input logic [63:0] mask);
        return ^(v & mask);
    endfunction

endpackage

// File: rtl/a5_keystream_gen_if.sv
// a5_keystream_gen_if: control and keystream handshake bundle of the A5 generator
// Signals:
//   start/key/frame      - session request with key and frame number
//   busy/done            - session status, done is a one-cycle end pulse
//   ks_valid/ks_ready    - keystream bit handshake
//   ks_bit/burst_idx/burst_last - keystream bit and its burst position
// Modports: master drives requests and ready, slave is the generator.
interface a5_keystream_gen_if #(
    parameter int KEYLEN   = 64,
    parameter int FRAMELEN = 22,
    parameter int NBURSTS  = 2
);
    logic                         start;
    logic [KEYLEN-1:0]            key;
    logic [FRAMELEN-1:0]          frame;
    logic                         busy;
    logic                         ks_valid;
    logic                         ks_ready;
    logic                         ks_bit;
    logic [$clog2(NBURSTS):0]     burst_idx;
    logic                         burst_last;
    logic                         done;

    modport master (
        output start, key, frame, ks_ready,
        input  busy, ks_valid, ks_bit, burst_idx, burst_last, done
    );

    modport slave (
        input  start, key, frame, ks_ready,
        output busy, ks_valid, ks_bit, burst_idx, burst_last, done
    );
endinterface

// File: rtl/a5_keystream_gen_lfsr.sv
// a5_lfsr: one Fibonacci LFSR of the A5 family with bit injection
// Ports:
//   i_clk, i_rst - clock, async active-high reset (register cleared)
//   i_clr        - synchronous clear at session start
//   i_shift      - shift once this cycle
//   i_inj        - bit XORed into the new bit0 (key/frame loading)
//   o_clk_tap    - majority clocking tap R[CLKBIT]
//   o_msb        - output tap R[LEN-1]
module a5_lfsr
    import a5_pkg::*;
#(
    parameter int             LEN    = 19,
    parameter logic [LEN-1:0] TAPS   = 19'h72000,
    parameter int             CLKBIT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_shift,
    input  logic i_inj,
    output logic o_clk_tap,
    output logic o_msb
);
    logic [LEN-1:0] r_reg;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_reg <= '0;
        else if (i_clr)
            r_reg <= '0;
        else if (i_shift)
            r_reg <= {r_reg[LEN-2:0], parity(64'(r_reg), 64'(TAPS)) ^ i_inj};

    assign o_clk_tap = r_reg[CLKBIT];
    assign o_msb     = r_reg[LEN-1];
endmodule

// File: rtl/a5_keystream_gen.sv
// a5_keystream_gen: A5/1-family keystream generator with key/frame load, mixing and burst output
// Ports:
//   i_clk, i_rst - clock, async active-high reset (aborts any session, no done)
//   io_ks        - slave side of a5_keystream_gen_if: start/key/frame in,
//                  busy/done status, ks_valid/ks_ready/ks_bit stream with
//                  burst_idx and burst_last position flags
module a5_keystream_gen
    import a5_pkg::*;
#(
    parameter int               R1LEN    = A5_R1LEN,
    parameter int               R2LEN    = A5_R2LEN,
    parameter int               R3LEN    = A5_R3LEN,
    parameter logic [R1LEN-1:0] TAPS1    = A5_TAPS1,
    parameter logic [R2LEN-1:0] TAPS2    = A5_TAPS2,
    parameter logic [R3LEN-1:0] TAPS3    = A5_TAPS3,
    parameter int               CLK1     = A5_CLK1,
    parameter int               CLK2     = A5_CLK2,
    parameter int               CLK3     = A5_CLK3,
    parameter int               KEYLEN   = 64,
    parameter int               FRAMELEN = 22,
    parameter int               MIXLEN   = 100,
    parameter int               BURSTLEN = 114,
    parameter int               NBURSTS  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    a5_keystream_gen_if.slave  io_ks
);
    // one counter serves every phase, so size it for the longest one
    localparam int M1     = KEYLEN > FRAMELEN ? KEYLEN : FRAMELEN;
    localparam int M2     = M1 > MIXLEN + 1 ? M1 : MIXLEN + 1;
    localparam int CNTMAX = M2 > BURSTLEN ? M2 : BURSTLEN;
    localparam int CW     = $clog2(CNTMAX + 1);
    localparam int BW     = $clog2(NBURSTS) + 1;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt, w_cnt;
    logic [BW-1:0]       r_bidx, w_bidx;
    logic [KEYLEN-1:0]   r_key;
    logic [FRAMELEN-1:0] r_frame;
    logic                r_done, w_done;
    logic                w_fire, w_cnt_end, w_last_burst, w_final;
    logic                w_clr, w_load, w_step, w_inj, w_maj;
    logic                w_t1, w_t2, w_t3, w_m1, w_m2, w_m3;
    logic                w_sh1, w_sh2, w_sh3;

    assign w_fire       = (r_state == GEN) & io_ks.ks_ready;
    assign w_cnt_end    = r_cnt == CW'(r_state == LOADK ? KEYLEN - 1 :
                                       r_state == LOADF ? FRAMELEN - 1 :
                                       r_state == MIX   ? MIXLEN : BURSTLEN - 1);
    assign w_last_burst = r_bidx == BW'(NBURSTS - 1);
    assign w_final      = w_fire & w_cnt_end & w_last_burst;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_bidx = r_bidx;
        w_done = 1'b0;
        case (r_state)
            IDLE:
                if (io_ks.start) begin
                    w_next = LOADK;
                    w_cnt  = '0;
                    w_bidx = '0;
                end
            LOADK, LOADF, MIX: begin
                w_cnt = w_cnt_end ? '0 : r_cnt + 1'b1;
                if (w_cnt_end)
                    w_next = r_state == LOADK ? LOADF : r_state == LOADF ? MIX : GEN;
            end
            GEN:
                if (w_fire) begin
                    w_cnt  = w_cnt_end ? '0 : r_cnt + 1'b1;
                    w_bidx = w_cnt_end ? r_bidx + 1'b1 : r_bidx;
                    if (w_final) begin
                        w_next = IDLE;
                        w_bidx = '0;
                        w_done = 1'b1;
                    end
                end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_done  <= 1'b0;
            r_key   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_bidx  <= w_bidx;
            r_done  <= w_done;
            if (w_clr) begin
                r_key   <= io_ks.key;
                r_frame <= io_ks.frame;
            end else begin
                if (r_state == LOADK)
                    r_key <= r_key >> 1;
                if (r_state == LOADF)
                    r_frame <= r_frame >> 1;
            end
        end

    // loading clocks all registers; MIX and each accepted bit (except the
    // very last one) clock only registers whose tap agrees with the majority
    assign w_clr  = (r_state == IDLE) & io_ks.start;
    assign w_load = (r_state == LOADK) | (r_state == LOADF);
    assign w_step = (r_state == MIX) | (w_fire & ~w_final);
    assign w_inj  = ((r_state == LOADK) & r_key[0]) | ((r_state == LOADF) & r_frame[0]);
    assign w_maj  = majority(w_t1, w_t2, w_t3);
    assign w_sh1  = w_load | (w_step & (w_t1 == w_maj));
    assign w_sh2  = w_load | (w_step & (w_t2 == w_maj));
    assign w_sh3  = w_load | (w_step & (w_t3 == w_maj));

    a5_lfsr #(.LEN(R1LEN), .TAPS(TAPS1), .CLKBIT(CLK1)) u_r1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_shift(w_sh1),
        .i_inj(w_inj), .o_clk_tap(w_t1), .o_msb(w_m1)
    );
    a5_lfsr #(.LEN(R2LEN), .TAPS(TAPS2), .CLKBIT(CLK2)) u_r2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_shift(w_sh2),
        .i_inj(w_inj), .o_clk_tap(w_t2), .o_msb(w_m2)
    );
    a5_lfsr #(.LEN(R3LEN), .TAPS(TAPS3), .CLKBIT(CLK3)) u_r3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_shift(w_sh3),
        .i_inj(w_inj), .o_clk_tap(w_t3), .o_msb(w_m3)
    );

    assign io_ks.busy       = r_state != IDLE;
    assign io_ks.ks_valid   = r_state == GEN;
    assign io_ks.ks_bit     = (r_state == GEN) & (w_m1 ^ w_m2 ^ w_m3);
    assign io_ks.burst_last = (r_state == GEN) & (r_cnt == CW'(BURSTLEN - 1));
    assign io_ks.burst_idx  = r_bidx;
    assign io_ks.done       = r_done;
endmodule

// File: tb/tb_a5_keystream_gen.sv
// tb_a5_keystream_gen: scoreboard bench for a5_keystream_gen against the reference A5/1 vector
module tb_a5_keystream_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a5_keystream_gen_if #(.KEYLEN(64), .FRAMELEN(22), .NBURSTS(2)) if0 ();
    a5_keystream_gen_if #(.KEYLEN(64), .FRAMELEN(22), .NBURSTS(1)) if1 ();

    a5_keystream_gen dut0 (.i_clk(clk), .i_rst(rst), .io_ks(if0));
    a5_keystream_gen #(.MIXLEN(0), .NBURSTS(1)) dut1 (.i_clk(clk), .i_rst(rst), .io_ks(if1));

    localparam logic [119:0] B0  = 120'h534EAA582FE8151AB6E1855A728C00;
    localparam logic [119:0] B1  = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    localparam logic [63:0]  KEY = 64'hEFCDAB8967452312;
    localparam logic [21:0]  FRM = 22'h134;

    typedef struct {
        logic b;
        logic last;
        int   idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   errors = 0;
    int   checks = 0;
    int   done0  = 0;
    int   done1  = 0;
    logic stall0 = 1'b0;
    logic sbit0  = 1'b0;
    int   nbit1  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_known();
        logic [119:0] v0;
        logic [119:0] v1;
        exp_t         e;
        v0 = B0;
        v1 = B1;
        for (int i = 0; i < 228; i++) begin
            e.b    = i < 114 ? v0[119 - i] : v1[119 - (i - 114)];
            e.last = (i % 114) == 113;
            e.idx  = i / 114;
            q0.push_back(e);
        end
    endtask

    // scoreboard monitors: compare each accepted bit against the queue head
    always @(negedge clk) begin
        if (rst) begin
            stall0 = 1'b0;
        end else begin
            if (if0.done)
                done0++;
            if (stall0 && if0.ks_valid)
                chk("stall_hold", if0.ks_bit, sbit0);
            if (if0.ks_valid && if0.ks_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit0: got bit %0b with empty queue", if0.ks_bit);
                end else begin
                    e0 = q0.pop_front();
                    chk($sformatf("ks_bit[%0d]", 227 - q0.size()), if0.ks_bit, e0.b);
                    chk($sformatf("burst_last[%0d]", 227 - q0.size()), if0.burst_last, e0.last);
                    chk($sformatf("burst_idx[%0d]", 227 - q0.size()), if0.burst_idx, e0.idx);
                end
            end
            stall0 = if0.ks_valid && !if0.ks_ready;
            sbit0  = if0.ks_bit;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (if1.done)
                done1++;
            if (if1.ks_valid && if1.ks_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit1: got bit %0b with empty queue", if1.ks_bit);
                end else begin
                    e1 = q1.pop_front();
                    chk($sformatf("zero_ks_bit[%0d]", nbit1), if1.ks_bit, e1.b);
                    chk($sformatf("zero_burst_last[%0d]", nbit1), if1.burst_last, e1.last);
                    chk($sformatf("zero_burst_idx[%0d]", nbit1), if1.burst_idx, e1.idx);
                    nbit1++;
                end
            end
        end
    end

    task automatic session(input logic [63:0] k, input logic [21:0] f, input bit rnd, input bit glitch);
        int t, d0, first_v, nv;
        bit seen;
        d0      = done0;
        first_v = -1;
        nv      = 0;
        seen    = 1'b0;
        push_known();
        if0.key   = k;
        if0.frame = f;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        if0.key   = ~k;
        if0.frame = ~f;
        t = 0;
        while (!seen && t < 3000) begin
            if0.ks_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if0.start    = glitch && (t == 50 || t == 300);
            @(posedge clk);
            #1;
            t++;
            if (if0.ks_valid) begin
                if (first_v < 0)
                    first_v = t;
                nv++;
            end
            seen = if0.done;
        end
        if0.start    = 1'b0;
        if0.ks_ready = 1'b1;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL session_timeout: got no done after %0d cycles, required 415", t);
        end else if (!rnd) begin
            chk("done_latency", t, 415);
            chk("first_valid", first_v, 187);
            chk("valid_cycles", nv, 228);
        end
        chk("valid_low_at_done", if0.ks_valid, 0);
        @(posedge clk);
        #1;
        chk("done_width", if0.done, 0);
        chk("busy_after", if0.busy, 0);
        @(negedge clk);
        chk("done_count", done0 - d0, 1);
        chk("queue_empty", q0.size(), 0);
    endtask

    task automatic abort_at(input int at);
        int d0;
        d0 = done0;
        push_known();
        if0.key   = KEY;
        if0.frame = FRM;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (at) @(posedge clk);
        #1;
        chk("abort_busy_before", if0.busy, 1);
        q0.delete();
        rst = 1'b1;
        #1;
        chk("abort_busy", if0.busy, 0);
        chk("abort_valid", if0.ks_valid, 0);
        chk("abort_bit", if0.ks_bit, 0);
        chk("abort_last", if0.burst_last, 0);
        chk("abort_idx", if0.burst_idx, 0);
        chk("abort_done", if0.done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", done0 - d0, 0);
    endtask

    initial begin
        int t;
        exp_t e;
        if0.start = 1'b0;
        if0.key = '0;
        if0.frame = '0;
        if0.ks_ready = 1'b1;
        if1.start = 1'b0;
        if1.key = '0;
        if1.frame = '0;
        if1.ks_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", if0.busy, 0);
        chk("rst_valid", if0.ks_valid, 0);
        chk("rst_bit", if0.ks_bit, 0);
        chk("rst_last", if0.burst_last, 0);
        chk("rst_idx", if0.burst_idx, 0);
        chk("rst_done", if0.done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        session(KEY, FRM, 1'b0, 1'b0);
        session(KEY, FRM, 1'b1, 1'b0);
        session(KEY, FRM, 1'b0, 1'b1);
        abort_at(120);
        abort_at(250);
        session(KEY, FRM, 1'b0, 1'b0);
        // NBURSTS=1, MIXLEN=0 instance with an all-zero key and frame
        for (int i = 0; i < 114; i++) begin
            e.b = 1'b0;
            e.last = i == 113;
            e.idx = 0;
            q1.push_back(e);
        end
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        t = 0;
        while (!if1.done && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("zero_done_latency", t, 201);
        @(posedge clk);
        @(negedge clk);
        chk("zero_done_count", done1, 1);
        chk("zero_queue_empty", q1.size(), 0);
        chk("zero_busy", if1.busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
